// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - button/tick inputs and preset/edit/status outputs of the time-entry controller
interface time_set_ctrl_if;
  logic       tick_i;
  logic       btn_set;
  logic       btn_sel;
  logic       btn_inc;
  logic       btn_dec;
  logic [4:0] set_hrs_o;
  logic [5:0] set_min_o;
  logic [5:0] set_sec_o;
  logic [4:0] edit_hrs_o;
  logic [5:0] edit_min_o;
  logic [5:0] edit_sec_o;
  logic [1:0] field_o;
  logic       load_o;

  modport master (
    output tick_i, btn_set, btn_sel, btn_inc, btn_dec,
    input  set_hrs_o, set_min_o, set_sec_o,
    input  edit_hrs_o, edit_min_o, edit_sec_o, field_o, load_o
  );

  modport slave (
    input  tick_i, btn_set, btn_sel, btn_inc, btn_dec,
    output set_hrs_o, set_min_o, set_sec_o,
    output edit_hrs_o, edit_min_o, edit_sec_o, field_o, load_o
  );
endinterface

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - button-driven time-entry controller with shadow edit and one-cycle commit pulse
// Define AUTO_REPEAT_EN to enable hold-to-repeat on btn_inc/btn_dec.
module time_set_ctrl #(
  parameter int HRS_INIT      = 17,
  parameter int MIN_INIT      = 35,
  parameter int SEC_INIT      = 42,
  parameter int HRS_MAX       = 23,
  parameter int TIMEOUT_TICKS = 10000,
  parameter int RPT_DELAY     = 500,
  parameter int RPT_PERIOD    = 100
) (
  input  logic            clk_i,
  input  logic            reset_i,
  time_set_ctrl_if.slave  bus
);

  // Timeout and repeat counters share one width sized for the largest tick count.
  localparam int MAX_A   = (TIMEOUT_TICKS > RPT_DELAY) ? TIMEOUT_TICKS : RPT_DELAY;
  localparam int MAX_T   = (MAX_A > RPT_PERIOD) ? MAX_A : RPT_PERIOD;
  localparam int CW      = $clog2(MAX_T + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_TICKS - 1);
  localparam logic [5:0] HRS_TOP  = 6'(HRS_MAX);
  localparam logic [5:0] MS_TOP   = 6'd59;

  typedef enum logic [2:0] {S_IDLE, S_HRS, S_MIN, S_SEC, S_COMMIT} state_t;

  state_t        r_state;
  logic          r_set_d, r_sel_d, r_inc_d, r_dec_d;
  logic [4:0]    r_set_hrs, r_edit_hrs;
  logic [5:0]    r_set_min, r_edit_min;
  logic [5:0]    r_set_sec, r_edit_sec;
  logic [1:0]    r_field;
  logic          r_load;
  logic [CW-1:0] r_tmo;

  logic w_set_ev, w_sel_ev, w_inc_ev, w_dec_ev;
  logic w_rpt_up, w_rpt_dn;
  logic w_step_up, w_step_dn, w_any_ev, w_edit;

  function automatic logic [5:0] f_up(input logic [5:0] v, input logic [5:0] vmax);
    if (v >= vmax) return 6'd0;
    return v + 6'd1;
  endfunction

  function automatic logic [5:0] f_dn(input logic [5:0] v, input logic [5:0] vmax);
    if ((v == 6'd0) || (v > vmax)) return vmax;
    return v - 6'd1;
  endfunction

  assign w_set_ev  = bus.btn_set & ~r_set_d;
  assign w_sel_ev  = bus.btn_sel & ~r_sel_d;
  assign w_inc_ev  = bus.btn_inc & ~r_inc_d;
  assign w_dec_ev  = bus.btn_dec & ~r_dec_d;
  assign w_edit    = (r_state == S_HRS) || (r_state == S_MIN) || (r_state == S_SEC);
  assign w_step_up = (w_inc_ev & ~w_dec_ev) | w_rpt_up;
  assign w_step_dn = (w_dec_ev & ~w_inc_ev) | w_rpt_dn;
  assign w_any_ev  = w_set_ev | w_sel_ev | w_inc_ev | w_dec_ev | w_rpt_up | w_rpt_dn;

`ifdef AUTO_REPEAT_EN
  localparam logic [CW-1:0] RPT_D_LAST = CW'(RPT_DELAY - 1);
  localparam logic [CW-1:0] RPT_P_LAST = CW'(RPT_PERIOD - 1);

  logic [CW-1:0] r_rpt_cnt;
  logic          r_rpt_armed;
  logic          w_hold, w_rpt_restart, w_rpt_fire;

  // A fresh press, field change or second button restarts the hold timer.
  assign w_hold        = w_edit & (bus.btn_inc ^ bus.btn_dec);
  assign w_rpt_restart = ~w_hold | w_inc_ev | w_dec_ev | w_sel_ev | w_set_ev;
  assign w_rpt_fire    = ~w_rpt_restart & bus.tick_i &
                         ((~r_rpt_armed & (r_rpt_cnt == RPT_D_LAST)) |
                          ( r_rpt_armed & (r_rpt_cnt == RPT_P_LAST)));
  assign w_rpt_up      = w_rpt_fire & bus.btn_inc;
  assign w_rpt_dn      = w_rpt_fire & bus.btn_dec;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (w_rpt_restart) begin
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
    end else if (bus.tick_i) begin
      if (w_rpt_fire) begin
        r_rpt_cnt   <= '0;
        r_rpt_armed <= 1'b1;
      end else begin
        r_rpt_cnt   <= r_rpt_cnt + 1'b1;
      end
    end
  end
`else
  assign w_rpt_up = 1'b0;
  assign w_rpt_dn = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state    <= S_IDLE;
      r_set_d    <= 1'b1;
      r_sel_d    <= 1'b1;
      r_inc_d    <= 1'b1;
      r_dec_d    <= 1'b1;
      r_set_hrs  <= 5'(HRS_INIT);
      r_set_min  <= 6'(MIN_INIT);
      r_set_sec  <= 6'(SEC_INIT);
      r_edit_hrs <= 5'(HRS_INIT);
      r_edit_min <= 6'(MIN_INIT);
      r_edit_sec <= 6'(SEC_INIT);
      r_field    <= 2'd0;
      r_load     <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_set_d <= bus.btn_set;
      r_sel_d <= bus.btn_sel;
      r_inc_d <= bus.btn_inc;
      r_dec_d <= bus.btn_dec;
      r_load  <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_field <= 2'd0;
          r_tmo   <= '0;
          if (w_set_ev) begin
            r_state    <= S_HRS;
            r_field    <= 2'd1;
            r_edit_hrs <= r_set_hrs;
            r_edit_min <= r_set_min;
            r_edit_sec <= r_set_sec;
          end
        end

        S_HRS, S_MIN, S_SEC: begin
          if (w_set_ev) begin
            // Commit is taken on entry so load_o is high during the COMMIT cycle.
            r_state   <= S_COMMIT;
            r_field   <= 2'd0;
            r_set_hrs <= r_edit_hrs;
            r_set_min <= r_edit_min;
            r_set_sec <= r_edit_sec;
            r_load    <= 1'b1;
            r_tmo     <= '0;
          end else if (w_sel_ev) begin
            r_tmo <= '0;
            case (r_state)
              S_HRS:   begin r_state <= S_MIN; r_field <= 2'd2; end
              S_MIN:   begin r_state <= S_SEC; r_field <= 2'd3; end
              default: begin r_state <= S_HRS; r_field <= 2'd1; end
            endcase
          end else if (w_step_up || w_step_dn) begin
            r_tmo <= '0;
            case (r_state)
              S_HRS:   r_edit_hrs <= w_step_up ? 5'(f_up({1'b0, r_edit_hrs}, HRS_TOP))
                                               : 5'(f_dn({1'b0, r_edit_hrs}, HRS_TOP));
              S_MIN:   r_edit_min <= w_step_up ? f_up(r_edit_min, MS_TOP) : f_dn(r_edit_min, MS_TOP);
              default: r_edit_sec <= w_step_up ? f_up(r_edit_sec, MS_TOP) : f_dn(r_edit_sec, MS_TOP);
            endcase
          end else if (w_any_ev) begin
            r_tmo <= '0;
          end else if (bus.tick_i) begin
            if (r_tmo == TMO_LAST) begin
              r_state    <= S_IDLE;
              r_field    <= 2'd0;
              r_edit_hrs <= r_set_hrs;
              r_edit_min <= r_set_min;
              r_edit_sec <= r_set_sec;
              r_tmo      <= '0;
            end else begin
              r_tmo <= r_tmo + 1'b1;
            end
          end
        end

        S_COMMIT: begin
          r_state <= S_IDLE;
          r_field <= 2'd0;
          r_tmo   <= '0;
        end

        default: begin
          r_state <= S_IDLE;
          r_field <= 2'd0;
          r_tmo   <= '0;
        end
      endcase
    end
  end

  assign bus.set_hrs_o  = r_set_hrs;
  assign bus.set_min_o  = r_set_min;
  assign bus.set_sec_o  = r_set_sec;
  assign bus.edit_hrs_o = r_edit_hrs;
  assign bus.edit_min_o = r_edit_min;
  assign bus.edit_sec_o = r_edit_sec;
  assign bus.field_o    = r_field;
  assign bus.load_o     = r_load;

endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed self-checking bench for time_set_ctrl (default build)
module tb_time_set_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  int   load_cnt;
  int   load_base;

  time_set_ctrl_if bus ();

  time_set_ctrl dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial load_cnt = 0;
  always @(negedge clk) if (bus.load_o === 1'b1) load_cnt = load_cnt + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic s, input logic sl, input logic up, input logic dn);
    bus.btn_set = s;
    bus.btn_sel = sl;
    bus.btn_inc = up;
    bus.btn_dec = dn;
  endtask

  task automatic press(input logic s, input logic sl, input logic up, input logic dn);
    drive(s, sl, up, dn);
    step();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic tick();
    bus.tick_i = 1'b1;
    step();
    bus.tick_i = 1'b0;
    step();
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    bus.tick_i = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    step();
    step();
    chk("rst_set_hrs", bus.set_hrs_o, 17);
    chk("rst_set_min", bus.set_min_o, 35);
    chk("rst_set_sec", bus.set_sec_o, 42);
    chk("rst_edit_hrs", bus.edit_hrs_o, 17);
    chk("rst_field", bus.field_o, 0);
    chk("rst_load", bus.load_o, 0);

    rst_n = 1'b1;
    step();
    step();
    chk("held_no_event_field", bus.field_o, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_inc_ignored", bus.edit_hrs_o, 17);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("idle_sel_ignored", bus.field_o, 0);

    press(1'b1, 1'b0, 1'b0, 1'b0);
    chk("enter_field", bus.field_o, 1);
    chk("enter_edit_hrs", bus.edit_hrs_o, 17);
    for (int i = 0; i < 7; i++) press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("hrs_wrap_up", bus.edit_hrs_o, 0);
    chk("hrs_set_untouched", bus.set_hrs_o, 17);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("hrs_wrap_down", bus.edit_hrs_o, 23);

    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sel_to_min", bus.field_o, 2);
    chk("min_start", bus.edit_min_o, 35);
    for (int i = 0; i < 36; i++) press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("min_wrap_down", bus.edit_min_o, 59);
    press(1'b0, 1'b0, 1'b1, 1'b1);
    chk("inc_dec_both", bus.edit_min_o, 59);
    chk("inc_dec_hrs", bus.edit_hrs_o, 23);

    press(1'b0, 1'b1, 1'b1, 1'b0);
    chk("sel_over_inc_field", bus.field_o, 3);
    chk("sel_over_inc_min", bus.edit_min_o, 59);
    chk("sel_over_inc_sec", bus.edit_sec_o, 42);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("sec_inc", bus.edit_sec_o, 43);

    load_base = load_cnt;
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("commit_load", bus.load_o, 1);
    chk("commit_field", bus.field_o, 0);
    chk("commit_hrs", bus.set_hrs_o, 23);
    chk("commit_min", bus.set_min_o, 59);
    chk("commit_sec_set_wins", bus.set_sec_o, 43);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("commit_load_drop", bus.load_o, 0);
    step();
    chk("commit_load_count", load_cnt - load_base, 1);
    chk("after_commit_field", bus.field_o, 0);

    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    chk("sel_wrap_to_hrs", bus.field_o, 1);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_edit_hrs", bus.edit_hrs_o, 22);
    load_base = load_cnt;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_set_hrs", bus.set_hrs_o, 17);
    chk("midrst_set_sec", bus.set_sec_o, 42);
    chk("midrst_edit_hrs", bus.edit_hrs_o, 17);
    chk("midrst_field", bus.field_o, 0);
    step();

    press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    chk("tmo_edit_hrs", bus.edit_hrs_o, 18);
    for (int i = 0; i < 9999; i++) tick();
    chk("tmo_not_yet", bus.field_o, 1);
    tick();
    chk("tmo_field", bus.field_o, 0);
    chk("tmo_edit_reload", bus.edit_hrs_o, 17);
    chk("tmo_set_hrs", bus.set_hrs_o, 17);
    chk("tmo_no_load", load_cnt - load_base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
